// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the HI/LO multiply/divide unit.
// Op encodings, FSM state type and iteration count.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int MD_ITERS = 32;
  localparam int CNT_W    = $clog2(MD_ITERS);

  function automatic logic is_mul_op(input op_e o);
    return ~o[1];
  endfunction

  function automatic logic is_signed_op(input op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// div_step: one restoring-division iteration on magnitudes.
// Shifts in the next dividend bit and subtracts the divisor if it fits.
module div_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // trial subtraction; the borrow bit decides restore or keep
  always_comb begin
    shifted = {rem_in, bit_in};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    rem_out = q_bit ? trial[WIDTH-1:0]
                    : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO.
// Optional MULDIV_FAST_MULT_EN: single-cycle combinational multiply.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e state;
  state_e state_nx;

  logic [CNT_W-1:0]   cnt;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [2*WIDTH-1:0] acc;
  logic               b_zero;
  logic               neg_q;
  logic               neg_r;

  op_e              op_in;
  logic             sgn_in;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             accept;
  logic             last;
  logic             mt_ok;
  logic             fast_go;

  assign op_in  = op_e'(op);
  assign sgn_in = is_signed_op(op_in);
  assign a_neg  = sgn_in & srca[WIDTH-1];
  assign b_neg  = sgn_in & srcb[WIDTH-1];
  assign mag_a  = a_neg ? -srca : srca;
  assign mag_b  = b_neg ? -srcb : srcb;
  assign accept = (state == IDLE) & start;
  assign mt_ok  = (state == IDLE) & ~start;
  assign last   = (state == RUN) &
                  (cnt == CNT_W'(MD_ITERS - 1));

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] fast_prod;

  assign ext_a     = {{WIDTH{a_neg}}, srca};
  assign ext_b     = {{WIDTH{b_neg}}, srcb};
  assign fast_prod = ext_a * ext_b;
  assign fast_go   = accept & is_mul_op(op_in);
`else
  assign fast_go = 1'b0;
`endif

  // shift-add step: acc holds partial product above multiplier bits
  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] acc_nx;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    psum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
           + (acc[0] ? {1'b0, opnd} : '0);
    acc_nx = {psum, acc[WIDTH-1:1]};
    prod   = neg_q ? -acc_nx : acc_nx;
  end

  logic [WIDTH-1:0] rem_nx;
  logic             qb;
  logic [WIDTH-1:0] quo_nx;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_in  (rem),
    .bit_in  (quo[WIDTH-1]),
    .divisor (opnd),
    .rem_out (rem_nx),
    .q_bit   (qb)
  );

  assign quo_nx = {quo[WIDTH-2:0], qb};

  // final HI/LO selection with sign fix-up and divide-by-zero
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             sel_mul;
  logic             sel_dz;
  logic             sel_div;

  always_comb begin
    sel_mul = is_mul_op(op_q);
    sel_dz  = ~sel_mul & b_zero;
    sel_div = ~sel_mul & ~b_zero;
    res_hi  = '0;
    res_lo  = '0;
    unique case (1'b1)
      sel_mul: begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
      end
      sel_dz: begin
        res_hi = a_q;
        res_lo = '1;
      end
      sel_div: begin
        res_hi = neg_r ? -rem_nx : rem_nx;
        res_lo = neg_q ? -quo_nx : quo_nx;
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state: IDLE -> RUN (or DONE for fast multiply) -> DONE -> IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = fast_go ? DONE : RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // status outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // operand latch, iteration registers and HI/LO updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      op_q   <= OP_MULT;
      a_q    <= '0;
      opnd   <= '0;
      rem    <= '0;
      quo    <= '0;
      acc    <= '0;
      b_zero <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      cnt    <= '0;
      op_q   <= op_in;
      a_q    <= srca;
      b_zero <= (srcb == '0);
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      opnd   <= is_mul_op(op_in) ? mag_a : mag_b;
      acc    <= {{WIDTH{1'b0}}, mag_b};
      rem    <= '0;
      quo    <= mag_a;
`ifdef MULDIV_FAST_MULT_EN
      if (fast_go) begin
        hi <= fast_prod[2*WIDTH-1:WIDTH];
        lo <= fast_prod[WIDTH-1:0];
      end
`endif
    end else if (state == RUN) begin
      cnt <= cnt + CNT_W'(1);
      acc <= acc_nx;
      rem <= rem_nx;
      quo <= quo_nx;
      if (last) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if (mt_ok) begin
      if (hi_we) begin
        hi <= wd;
      end
      if (lo_we) begin
        lo <= wd;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors plus a cycle-level arithmetic model
// compared on every falling edge.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wd = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  function automatic int lat_for(input logic [1:0] o);
    return (o[1] == 1'b0) ? MUL_LAT : DIV_LAT;
  endfunction

  // {hi,lo} from plain arithmetic
  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = 0;
    r = 0;
    case (o)
      2'b00: return 64'(sa * sb);
      2'b01: return {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'({32'd0, a}) / longint'({32'd0, b});
          r = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // model: cycles remaining until idle (1 = the done cycle)
  int          left;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      left <= 0;
      m_hi <= '0;
      m_lo <= '0;
      p_hi <= '0;
      p_lo <= '0;
    end else if (left == 0) begin
      if (start) begin
        {p_hi, p_lo} <= model(op, srca, srcb);
        left <= lat_for(op);
        if (lat_for(op) == 1) {m_hi, m_lo} <= model(op, srca, srcb);
      end else begin
        if (hi_we) m_hi <= wd;
        if (lo_we) m_lo <= wd;
      end
    end else begin
      left <= left - 1;
      if (left == 2) {m_hi, m_lo} <= {p_hi, p_lo};
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks += 4;
      if (busy !== (left > 0)) begin
        errors++;
        $display("FAIL cmp_busy t=%0t got=%b exp=%b", $time, busy, left > 0);
      end
      if (done !== (left == 1)) begin
        errors++;
        $display("FAIL cmp_done t=%0t got=%b exp=%b", $time, done, left == 1);
      end
      if (hi !== m_hi) begin
        errors++;
        $display("FAIL cmp_hi t=%0t got=%h exp=%h", $time, hi, m_hi);
      end
      if (lo !== m_lo) begin
        errors++;
        $display("FAIL cmp_lo t=%0t got=%h exp=%h", $time, lo, m_lo);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    @(posedge clk);
    #1;
    start = 1'b1;
    op = o;
    srca = a;
    srcb = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = ~o;
    srca = ~a ^ 32'h5A5A5A5A;
    srcb = b + 32'd7;
  endtask

  task automatic wait_done(input string name, input int lat, input bit lit,
                           input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout got=no_done exp=done", name);
    end else begin
      check({name, "_lat"}, 32'(n), 32'(lat));
      if (lit) begin
        check({name, "_hi"}, hi, ehi);
        check({name, "_lo"}, lo, elo);
      end
    end
  endtask

  task automatic run(input string name, input logic [1:0] o,
                     input logic [31:0] a, input logic [31:0] b,
                     input bit lit, input logic [31:0] ehi,
                     input logic [31:0] elo);
    issue(o, a, b);
    wait_done(name, lat_for(o), lit, ehi, elo);
  endtask

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    run("multu_max2", 2'b01, 32'hFFFFFFFF, 32'd2, 1'b1,
        32'h00000001, 32'hFFFFFFFE);
    run("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 1'b1,
        32'hFFFFFFFF, 32'hFFFFFFEB);
    run("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 1'b1,
        32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divu_zero", 2'b11, 32'd100, 32'd0, 1'b1,
        32'd100, 32'hFFFFFFFF);
    run("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b1,
        32'h00000000, 32'h80000000);
    run("div_zero", 2'b10, 32'hFFFFFFF9, 32'd0, 1'b1,
        32'hFFFFFFF9, 32'hFFFFFFFF);
    run("mult_minmin", 2'b00, 32'h80000000, 32'h80000000, 1'b1,
        32'h40000000, 32'h00000000);
    run("multu_maxmax", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
        32'hFFFFFFFE, 32'h00000001);
    run("div_pos_neg", 2'b10, 32'd100, 32'hFFFFFFF9, 1'b1,
        32'd2, 32'hFFFFFFF2);
    run("divu_big", 2'b11, 32'hFFFFFFFF, 32'd10, 1'b1,
        32'd5, 32'h19999999);

    for (int i = 0; i < 6; i++) begin
      run("rand", 2'($urandom_range(0, 3)), $urandom,
          $urandom >> (8 * (i % 4)), 1'b0, '0, '0);
    end

    @(posedge clk);
    #1;
    hi_we = 1'b1;
    lo_we = 1'b1;
    wd = 32'h1234;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    @(negedge clk);
    check("mt_hi", hi, 32'h1234);
    check("mt_lo", lo, 32'h1234);
    hi_we = 1'b1;
    wd = 32'hABCD;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    @(negedge clk);
    check("mthi_only_hi", hi, 32'hABCD);
    check("mthi_only_lo", lo, 32'h1234);

    start = 1'b1;
    op = 2'b11;
    srca = 32'd20;
    srcb = 32'd6;
    hi_we = 1'b1;
    lo_we = 1'b1;
    wd = 32'hDEAD;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    srca = '0;
    srcb = '0;
    check("strobe_ign_hi", hi, 32'hABCD);
    check("strobe_ign_lo", lo, 32'h1234);
    check("strobe_busy", {31'd0, busy}, 32'd1);
    wait_done("mt_start", DIV_LAT, 1'b1, 32'd2, 32'd3);

    issue(2'b11, 32'd10, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1;
    op = 2'b01;
    srca = 32'd3;
    srcb = 32'd3;
    hi_we = 1'b1;
    wd = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    check("busy_ign_hi", hi, 32'd2);
    check("busy_ign_busy", {31'd0, busy}, 32'd1);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midrst_no_done got=done exp=no_done");
    end
    run("divu_after_rst", 2'b11, 32'd10, 32'd3, 1'b1, 32'd1, 32'd3);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have exactly one clock and one reset: reset is asynchronous and active-high.
REQ-002 Parameter: WIDTH, 32, operand/HI/LO width; only 32 is supported.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  async active-high reset.
REQ-005 Port: start  in  1  request to begin an operation; sampled only in IDLE.
REQ-006 Port: op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 Port: srca  in  WIDTH  rs operand (multiplicand/dividend) from the register file.
REQ-008 Port: srcb  in  WIDTH  rt operand (multiplier/divisor) from the register file.
REQ-009 Port: hi_we, lo_we  in  1 each  MTHI/MTLO write strobes.
REQ-010 Port: wd  in  WIDTH  MTHI/MTLO write data.
REQ-011 Port: busy  out  1  high in RUN and DONE.
REQ-012 Port: done  out  1  one-cycle pulse when the result is committed.
REQ-013 Port: hi, lo  out  WIDTH each  architectural HI/LO registers, for MFHI/MFLO.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 IDLE with start=1: latch op, srca and srcb, clear the iteration counter, and go to RUN on the same edge.
REQ-016 RUN: perform one iteration per cycle for 32 cycles (counter 0..31), then go to DONE.
REQ-017 Entering DONE: write HI and LO on that edge; done=1 for the single DONE cycle; return to IDLE on the next edge.
REQ-018 Latency: start edge to done high is exactly 33 cycles; HI/LO hold the new values while done=1.
REQ-019 Multiply: {HI,LO} = 64-bit product; MULT is signed, MULTU is unsigned; uses iterative shift-add.
REQ-020 Divide: LO = quotient, HI = remainder.
REQ-021 DIV: quotient truncates toward zero; the remainder takes the sign of the dividend; implemented as magnitude restoring division with sign fix-up.
REQ-022 Divide by zero (DIV or DIVU): HI = srca and LO = 32'hFFFFFFFF, with normal latency.
REQ-023 DIV of 32'h80000000 by 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
REQ-024 start outside IDLE is ignored; no queuing.
REQ-025 Latched operands are used; changes on srca/srcb after the start edge have no effect.
REQ-026 hi_we/lo_we in IDLE with start=0: write wd into HI/LO on the next edge; both may be written in the same cycle.
REQ-027 hi_we/lo_we while busy, or together with start: ignored; start has priority.
REQ-028 HI/LO change only on an MTHI/MTLO write, on DONE entry, or on reset.

Reset
REQ-029 On reset, at any time including mid-RUN: state = IDLE, counter = 0, hi = lo = 0, busy = 0, done = 0; any in-flight result is discarded.
REQ-030 The first start after reset is deassertion SHALL be accepted normally.

Configuration
REQ-031 Macro MULDIV_FAST_MULT_EN:
- Defined: MULT/MULTU skip RUN and go from IDLE directly to DONE, using a combinational 64-bit product; latency start to done is 1 cycle.
- Undefined: multiplies use the 32-iteration path, with the REQ-018 latency.
- Divide latency is unaffected in both cases.

Structure
REQ-032 Package muldiv_pkg SHALL hold:
- the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
- the FSM state type;
- the constant MD_ITERS = 32.
REQ-033 One sub-module div_step SHALL perform one combinational restoring-divide iteration (partial remainder, divisor in; next remainder and quotient bit out); everything else is in muldiv_unit.

Verification
REQ-034 MULTU: srca=32'hFFFFFFFF, srcb=2 -> after 33 cycles, done pulse, hi=1, lo=32'hFFFFFFFE.
REQ-035 MULT: srca=-3 (32'hFFFFFFFD), srcb=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; with MULDIV_FAST_MULT_EN, done follows 1 cycle after start.
REQ-036 DIV: srca=-7, srcb=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); DIVU: srca=100, srcb=0 -> hi=100, lo=32'hFFFFFFFF.
REQ-037 Start DIVU 10/3, assert start plus hi_we=1 (wd=5) at cycle 10, then pulse reset at cycle 20:
- the second start and hi_we are ignored while busy;
- after reset: hi=lo=0, busy=0, no done pulse;
- a new DIVU 10/3 then gives lo=3, hi=1.
REQ-038 In IDLE, hi_we=1 and lo_we=1 with wd=32'h1234 -> next cycle hi=lo=32'h1234; the same strobes with start=1 -> no write, and the operation starts.
